// File: rtl/hazard_pkg.sv
// Shared codes, widths and the writer descriptor for the hazard/forwarding controller.
// No timing of its own; consumed by hz_stage_reg and hazard_fwd_ctrl.
// No flow control; pure type and constant definitions.
package hazard_pkg;

    localparam int RA_W = 5;
    localparam int T_W  = 2;

    localparam logic [1:0] SEL_RF = 2'd0;
    localparam logic [1:0] SEL_W  = 2'd1;
    localparam logic [1:0] SEL_M  = 2'd2;
    localparam logic [1:0] SEL_E  = 2'd3;

    localparam logic [RA_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [RA_W-1:0] a3;
        logic            we;
        logic [T_W-1:0]  tnew;
        logic [RA_W-1:0] a1;
        logic [RA_W-1:0] a2;
        logic            is_md;
    } desc_t;

    // Saturating one-cycle age of a result countdown.
    function automatic logic [T_W-1:0] tnew_dec(input logic [T_W-1:0] t);
        return (t == '0) ? '0 : t - T_W'(1);
    endfunction

endpackage

// File: rtl/hz_stage_reg.sv
// One shadow pipeline stage holding a writer descriptor.
// Latency: one clock from nxt to cur; tnew optionally aged or cleared on load.
// Backpressure: none; bubble replaces the incoming descriptor with an empty one.
module hz_stage_reg
    import hazard_pkg::*;
#(
    parameter bit DEC_TNEW  = 1'b1,
    parameter bit ZERO_TNEW = 1'b0
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  bubble,
    input  desc_t nxt,
    output desc_t cur
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur <= '0;
        end else if (bubble) begin
            cur <= '0;
        end else begin
            cur <= nxt;
            if (ZERO_TNEW)
                cur.tnew <= '0;
            else if (DEC_TNEW)
                cur.tnew <= tnew_dec(nxt.tnew);
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard detection and forwarding-select generation for a 5-stage MIPS pipeline.
// Latency: selects and stall are combinational from the E/M/W shadow and D inputs.
// Backpressure: stall freezes PC and IF/ID and pushes a bubble into E; flush also bubbles.
module hazard_fwd_ctrl
    import hazard_pkg::*;
#(
    parameter int RW     = 5,
    parameter int TW     = 2,
    parameter int SW     = 2,
    parameter int MD_LAT = 5,
    parameter int CW     = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [RW-1:0] d_a1,
    input  logic [RW-1:0] d_a2,
    input  logic          d_use_rs,
    input  logic          d_use_rt,
    input  logic [TW-1:0] d_tuse_rs,
    input  logic [TW-1:0] d_tuse_rt,
    input  logic [RW-1:0] d_a3,
    input  logic          d_we,
    input  logic [TW-1:0] d_tnew,
    input  logic          d_md_start,
    input  logic          d_md_use,
    input  logic          flush,
    output logic          stall,
    output logic [SW-1:0] d_sel_rs,
    output logic [SW-1:0] d_sel_rt,
    output logic [SW-1:0] e_sel_rs,
    output logic [SW-1:0] e_sel_rt,
    output logic [SW-1:0] m_sel_rt,
    output logic          md_busy
);

    desc_t         d_desc, e, m, w;
    logic          e_bubble;
    logic [CW-1:0] md_cnt;
    logic          unused_fields;

    function automatic logic hit(input desc_t s, input logic [RA_W-1:0] r);
        return s.we && (s.a3 == r) && (r != REG_ZERO);
    endfunction

    // A nearer matching writer whose result is not ready yet hides older copies.
    function automatic logic [SW-1:0] pick(input logic e_hit, input logic e_rdy,
                                           input logic m_hit, input logic m_rdy,
                                           input logic w_hit);
        if (e_hit) return e_rdy ? SW'(SEL_E) : SW'(SEL_RF);
        if (m_hit) return m_rdy ? SW'(SEL_M) : SW'(SEL_RF);
        if (w_hit) return SW'(SEL_W);
        return SW'(SEL_RF);
    endfunction

    assign d_desc = '{a3: d_a3, we: d_we, tnew: d_tnew,
                      a1: d_a1, a2: d_a2, is_md: d_md_start};

    assign e_bubble = stall || flush;

    hz_stage_reg #(.DEC_TNEW(1'b0), .ZERO_TNEW(1'b0)) u_stage_e (
        .clk    (clk),
        .reset  (reset),
        .bubble (e_bubble),
        .nxt    (d_desc),
        .cur    (e)
    );

    hz_stage_reg #(.DEC_TNEW(1'b1), .ZERO_TNEW(1'b0)) u_stage_m (
        .clk    (clk),
        .reset  (reset),
        .bubble (1'b0),
        .nxt    (e),
        .cur    (m)
    );

    hz_stage_reg #(.DEC_TNEW(1'b1), .ZERO_TNEW(1'b1)) u_stage_w (
        .clk    (clk),
        .reset  (reset),
        .bubble (1'b0),
        .nxt    (m),
        .cur    (w)
    );

    logic e_rs, e_rt, m_rs, m_rt, w_rs, w_rt;
    logic e_rdy, m_rdy, w_rdy;
    logic stall_rs, stall_rt, stall_md;

    assign e_rs  = hit(e, d_a1);
    assign e_rt  = hit(e, d_a2);
    assign m_rs  = hit(m, d_a1);
    assign m_rt  = hit(m, d_a2);
    assign w_rs  = hit(w, d_a1);
    assign w_rt  = hit(w, d_a2);
    assign e_rdy = (e.tnew == '0);
    assign m_rdy = (m.tnew == '0);
    assign w_rdy = (w.tnew == '0);

    assign d_sel_rs = pick(e_rs, e_rdy, m_rs, m_rdy, w_rs && w_rdy);
    assign d_sel_rt = pick(e_rt, e_rdy, m_rt, m_rdy, w_rt && w_rdy);
    assign e_sel_rs = pick(1'b0, 1'b0, hit(m, e.a1), m_rdy, hit(w, e.a1) && w_rdy);
    assign e_sel_rt = pick(1'b0, 1'b0, hit(m, e.a2), m_rdy, hit(w, e.a2) && w_rdy);
    assign m_sel_rt = pick(1'b0, 1'b0, 1'b0, 1'b0, hit(w, m.a2) && w_rdy);

    assign stall_rs = d_use_rs && ((e_rs && (e.tnew > d_tuse_rs)) ||
                                   (m_rs && (m.tnew > d_tuse_rs)));
    assign stall_rt = d_use_rt && ((e_rt && (e.tnew > d_tuse_rt)) ||
                                   (m_rt && (m.tnew > d_tuse_rt)));
    // E.is_md covers the cycle where the unit is issued but the counter is still loading.
    assign stall_md = d_md_use && (md_busy || e.is_md);
    assign stall    = stall_rs || stall_rt || stall_md;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            md_cnt <= '0;
        else if (d_md_start && !e_bubble)
            md_cnt <= CW'(MD_LAT);
        else if (md_cnt != '0)
            md_cnt <= md_cnt - CW'(1);
    end

    assign md_busy = (md_cnt != '0);

    assign unused_fields = ^{m.a1, m.is_md, w.a1, w.a2, w.is_md};

endmodule
